// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: pin synchroniser, 11-bit frame deserialiser and show-ahead scan-code FIFO.
// Define PS2_PARITY_CHECK_EN to make odd-parity failures reject a frame.
module ps2_keyboard #(
  parameter int FIFO_AW     = 3,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       pop,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, RECV} state_t;

  logic [2:0] csync;
  logic [1:0] dsync;
  logic       fall;
  logic       din;

  // Lines idle high, so the synchroniser resets to 1 to avoid a phantom falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      csync <= 3'b111;
      dsync <= 2'b11;
    end else begin
      csync <= {csync[1:0], ps2_clk};
      dsync <= {dsync[0], ps2_data};
    end
  end

  assign fall = csync[2] & ~csync[1];
  assign din  = dsync[1];

  state_t          state, state_n;
  logic [3:0]      cnt, cnt_n;
  logic [7:0]      shreg, shreg_n;
  logic            startb, startb_n;
  logic [TW-1:0]   tcnt, tcnt_n;
  logic            frame_ok;
  logic            push;
  logic            bad;

`ifdef PS2_PARITY_CHECK_EN
  logic par, par_n;

  always_ff @(posedge clk) begin
    if (rst) par <= 1'b0;
    else     par <= par_n;
  end

  assign frame_ok = ~startb & din & (^{shreg, par});
`else
  assign frame_ok = ~startb & din;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      shreg  <= 8'h00;
      startb <= 1'b0;
      tcnt   <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      shreg  <= shreg_n;
      startb <= startb_n;
      tcnt   <= tcnt_n;
    end
  end

  // At the stop-bit fall, frame_ok sees the live stop bit on din.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shreg_n  = shreg;
    startb_n = startb;
    tcnt_n   = tcnt;
    push     = 1'b0;
    bad      = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_n    = par;
`endif
    case (state)
      IDLE: begin
        tcnt_n = '0;
        if (fall) begin
          startb_n = din;
          cnt_n    = 4'd1;
          state_n  = RECV;
        end
      end
      RECV: begin
        if (fall) begin
          tcnt_n = '0;
          cnt_n  = cnt + 4'd1;
          if (cnt <= 4'd8) begin
            shreg_n = {din, shreg[7:1]};
          end
`ifdef PS2_PARITY_CHECK_EN
          if (cnt == 4'd9) begin
            par_n = din;
          end
`endif
          if (cnt == 4'd10) begin
            cnt_n   = 4'd0;
            state_n = IDLE;
            push    = frame_ok;
            bad     = ~frame_ok;
          end
        end else if (tcnt == TLAST) begin
          tcnt_n  = '0;
          cnt_n   = 4'd0;
          state_n = IDLE;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  logic [7:0]       mem [1 << FIFO_AW];
  logic [FIFO_AW:0] wptr, rptr, rnext;
  logic             empty, full, do_pop, do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                   (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rnext   = rptr + 1'b1;
  assign ready   = ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[FIFO_AW-1:0]] <= shreg;
  end

  // data is a registered head copy; a push bypasses into it when the FIFO would otherwise be empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      data      <= 8'h00;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= bad;
      if (push && full && !do_pop) overflow <= 1'b1;
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rnext;
      if (do_push && empty) begin
        data <= shreg;
      end else if (do_pop) begin
        if (rnext != wptr)  data <= mem[rnext[FIFO_AW-1:0]];
        else if (do_push)   data <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: directed scenarios plus randomized frames against a queue model.
module tb_ps2_keyboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       pop;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int errors = 0;
  int checks = 0;
  int errPulses = 0;
  int expErrPulses = 0;

  byte unsigned q[$];
  logic         modelOvf;

  always #5 clk = ~clk;

  ps2_keyboard dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .pop       (pop),
    .data      (data),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always @(negedge clk) if (frame_err === 1'b1) errPulses++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit frameGood(byte unsigned b, bit startB, bit parB, bit stopB);
`ifdef PS2_PARITY_CHECK_EN
    bit parOk;
    parOk = ((($countones(b) + int'(parB)) % 2) == 1);
    return !startB && stopB && parOk;
`else
    return !startB && stopB;
`endif
  endfunction

  function automatic bit oddPar(byte unsigned b);
    return ($countones(b) % 2) == 0;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the first nBits of a frame; a full frame is checked exactly at the FIFO write edge.
  task automatic applyStimulus(input byte unsigned b, input bit startB, input bit parB,
                               input bit stopB, input bit popAtStop, input int nBits);
    logic [10:0] bits;
    bit          good;
    bits = {stopB, parB, b, startB};
    for (int i = 0; i < nBits; i++) begin
      ps2_data = bits[i];
      cycles($urandom_range(3, 6));
      ps2_clk = 1'b0;
      if (i == 10) begin
        @(posedge clk);
        @(posedge clk);
        #1 if (popAtStop) pop = 1'b1;
        @(posedge clk);
        #1 pop = 1'b0;
        good = frameGood(b, startB, parB, stopB);
        if (popAtStop && q.size() > 0) void'(q.pop_front());
        if (good) begin
          if (q.size() < 8) q.push_back(b);
          else modelOvf = 1'b1;
        end else begin
          expErrPulses++;
        end
        checkOutput("frame_err", frame_err, !good);
        checkOutput("ready", ready, q.size() != 0);
        if (q.size() != 0) checkOutput("data", data, q[0]);
        checkOutput("overflow", overflow, modelOvf);
        @(posedge clk);
        #1 checkOutput("frame_err_width", frame_err, 1'b0);
        cycles(2);
      end else begin
        cycles($urandom_range(3, 6));
      end
      ps2_clk = 1'b1;
      cycles($urandom_range(3, 6));
    end
    ps2_data = 1'b1;
    cycles(4);
  endtask

  task automatic sendGood(input byte unsigned b);
    applyStimulus(b, 1'b0, oddPar(b), 1'b1, 1'b0, 11);
  endtask

  task automatic popCheck();
    @(negedge clk);
    if (q.size() != 0) begin
      checkOutput("pop_ready", ready, 1'b1);
      checkOutput("pop_data", data, q[0]);
    end else begin
      checkOutput("pop_empty_ready", ready, 1'b0);
    end
    pop = 1'b1;
    @(posedge clk);
    #1 pop = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    checkOutput("ready_after_pop", ready, q.size() != 0);
    if (q.size() != 0) checkOutput("data_after_pop", data, q[0]);
  endtask

  task automatic drain();
    while (q.size() != 0) popCheck();
    popCheck();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_data"}, data, 8'h00);
    checkOutput({tag, "_ready"}, ready, 1'b0);
    checkOutput({tag, "_overflow"}, overflow, 1'b0);
    checkOutput({tag, "_frame_err"}, frame_err, 1'b0);
  endtask

  initial begin
    byte unsigned b;
    int           kind;
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    pop = 1'b0;
    modelOvf = 1'b0;
    cycles(3);
    checkResetState("reset");
    rst = 1'b0;
    cycles(3);

    // Basic frame and single pop.
    applyStimulus(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 11);
    popCheck();

    // Wrong parity: rejected only when parity checking is built in.
    applyStimulus(8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 11);
    drain();

    // Nine frames without pops overflow the eight-entry FIFO.
    for (int i = 1; i <= 9; i++) sendGood(byte'(i));
    drain();

    // Reset mid-frame with three bytes queued.
    sendGood(8'h11);
    sendGood(8'h22);
    sendGood(8'h33);
    applyStimulus(8'h96, 1'b0, oddPar(8'h96), 1'b1, 1'b0, 6);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    q.delete();
    modelOvf = 1'b0;
    #1 checkResetState("midframe_reset");
    sendGood(8'h5A);
    drain();

    // Full FIFO with a pop on the commit edge of the ninth frame.
    for (int i = 1; i <= 8; i++) sendGood(byte'(i));
    applyStimulus(8'hAA, 1'b0, oddPar(8'hAA), 1'b1, 1'b1, 11);
    drain();

    // Abandoned partial frame followed by a clean one.
    applyStimulus(8'h3C, 1'b0, oddPar(8'h3C), 1'b1, 1'b0, 5);
    cycles(5100);
    sendGood(8'hF0);
    drain();

    // Randomized frames, error injection and pops.
    for (int n = 0; n < 25; n++) begin
      b = byte'($urandom_range(0, 255));
      kind = int'($urandom_range(0, 9));
      applyStimulus(b, kind == 0, (kind == 2) ? !oddPar(b) : oddPar(b), kind != 1,
                    $urandom_range(0, 4) == 0, 11);
      repeat ($urandom_range(0, 2)) popCheck();
    end
    drain();

    checkOutput("frame_err_pulse_count", errPulses, expErrPulses);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
# ps2_keyboard

PS/2 keyboard receiver: synchronises the raw `ps2_clk`/`ps2_data` lines, deserialises 11-bit device-to-host frames, checks framing, and buffers good scan codes in a small show-ahead FIFO. It sits directly upstream of the seven-segment display path. The consumer pops bytes and splits them into nibbles for the per-digit hex decoders.

## Interface
- `FIFO_AW`, 3: FIFO address width; depth = 2^FIFO_AW entries (8).
- `TIMEOUT_CYC`, 5000: idle `clk` cycles mid-frame before the frame is abandoned (100 µs at 50 MHz).
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `pop`  in  1  consumer takes `data`; honoured only when `ready`=1.
- `data`  out  8  FIFO head byte (show-ahead), valid while `ready`=1.
- `ready`  out  1  FIFO non-empty.
- `overflow`  out  1  sticky: a good frame was dropped because the FIFO was full.
- `frame_err`  out  1  one-cycle pulse: completed frame rejected.

## Operation
- Sync: `ps2_clk` passes through 3 flops s0→s1→s2; `fall` = s2 & ~s1. `ps2_data` passes through 2 flops and is sampled only when `fall`=1.
- Receiver FSM, bit counter `cnt` 0..10:
  - IDLE (cnt=0): on `fall`, capture the start bit and go to RECV with cnt=1.
  - RECV: on each `fall`, shift data in LSB-first for bits 1–8, store parity at bit 9, then increment cnt.
  - On the `fall` at cnt=10 (stop bit), evaluate the frame and return to IDLE.
- Frame good iff start=0, stop=1, and XOR(data[7:0], parity)=1 (odd parity).
  - Good frame: push `data` into the FIFO.
  - Bad frame: pulse `frame_err` for 1 cycle and push nothing.
- Timeout: a counter clears on every `fall` and increments in RECV. When it reaches `TIMEOUT_CYC`-1, go to IDLE with cnt=0. Nothing is pushed and `frame_err` is not pulsed. The counter is held at 0 in IDLE.
- FIFO: read/write pointers are FIFO_AW+1 bits wide.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the remaining bits are equal.
- Push while full without `pop`: byte dropped, `overflow` set; it stays set until `rst`.
- Push and `pop` in the same cycle while full: both are accepted, occupancy unchanged, no overflow.
- Push and `pop` in the same cycle at any other occupancy: both performed.
- `pop` while empty: ignored, pointers unchanged.
- Pointers wrap modulo 2^(FIFO_AW+1). No other wrap handling.

## Timing
- Reset values: `data`=8'h00, `ready`=0, `overflow`=0, `frame_err`=0, FSM in IDLE with cnt=0, pointers=0, timeout counter=0, sync flops=1 (idle-high lines).
- `rst` mid-frame: the partial frame is discarded and the FIFO is flushed on the same edge.
- `fall` is asserted in the cycle following the 2nd `clk` edge after the pin falls.
- FIFO write occurs on the edge ending the stop-bit `fall` cycle. `ready` and `data` become valid 3 `clk` edges after the 11th pin falling edge, ±1 edge of synchroniser uncertainty.
- `frame_err` is high for exactly the cycle after the stop-bit `fall`, aligned with when `ready` would have risen.
- `pop` takes effect at the edge where it is sampled; the next entry appears on `data` in the following cycle.
- `data` is registered and changes only on a push into an empty FIFO or on a `pop`.
- `ps2_clk` low/high phases must each last at least 3 `clk` cycles (guaranteed for PS/2 at ≥1 MHz `clk`).

## Configuration
- `PS2_PARITY_CHECK_EN` defined: the odd-parity failure is part of the bad-frame condition, as described above.
- `PS2_PARITY_CHECK_EN` undefined: the parity bit is shifted in but ignored. Only start/stop errors drop a frame and pulse `frame_err`. All other behaviour is identical.

## Test plan
- Send frame 8'h1C with correct parity=0 and stop=1 → 3 edges later `ready`=1, `data`=8'h1C. `pop` one cycle → `ready`=0 next cycle.
- Send 8'h1C with parity=1:
  - macro defined → `frame_err` pulses 1 cycle, `ready` stays 0.
  - macro undefined → `data`=8'h1C.
- Send 9 good frames 8'h01..8'h09 with no pops → `overflow`=1. Pops return 01..08 in order, then `ready`=0.
- With the FIFO full (8 entries), pulse `pop` in the stop-bit commit cycle of a 9th frame 8'hAA → no overflow. Draining returns 02..08 then AA.
- Send 5 bits of a frame, idle 5000 cycles, then a full 8'hF0 frame → only 8'hF0 is received and `frame_err` is never asserted.
- Assert `rst` at bit 6 of a frame with 3 bytes queued → all outputs return to reset values. A following frame 8'h5A is received correctly.
